// File: rtl/relu_engine.sv
// Streaming ReLU engine: runs a job of n beats through a two-stage pipeline,
// counting negative inputs and flagging beats that arrive outside RUN while busy.
module relu_engine #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  n,
  input  logic              DI_valid,
  input  logic [DATA_W-1:0] DI,
  output logic              DO_valid,
  output logic [DATA_W-1:0] DO,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  neg_cnt,
  output logic              overrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    n_q, n_d;
  logic [CNT_W-1:0]    in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0]    neg_q, neg_d;
  logic                ovr_q, ovr_d;
  logic                s1_vld_q, s1_vld_d;
  logic [DATA_W-1:0]   s1_dat_q, s1_dat_d;
  logic                do_vld_q, do_vld_d;
  logic [DATA_W-1:0]   do_q, do_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                accept_s;

  // Next-state, counters and pipeline advance
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    neg_d     = neg_q;
    ovr_d     = ovr_q;
    accept_s  = (state_q == S_RUN) && DI_valid;

    s1_vld_d  = accept_s;
    s1_dat_d  = accept_s ? DI : '0;
    do_vld_d  = s1_vld_q;
    do_d      = (s1_vld_q && !s1_dat_q[DATA_W-1]) ? s1_dat_q : '0;
    if (s1_vld_q) begin
      out_cnt_d = out_cnt_q + CNT_ONE;
    end else begin
      out_cnt_d = out_cnt_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d       = n;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          neg_d     = '0;
          ovr_d     = 1'b0;
          state_d   = (n != '0) ? S_RUN : S_DONE;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_RUN: begin
        if (DI_valid) begin
          in_cnt_d = in_cnt_q + CNT_ONE;
          if (DI[DATA_W-1]) begin
            neg_d = neg_q + CNT_ONE;
          end else begin
            neg_d = neg_q;
          end
          if ((in_cnt_q + CNT_ONE) == n_q) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        // out_cnt_q already includes the output currently on DO
        if (out_cnt_q == n_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
        if (DI_valid) begin
          ovr_d = 1'b1;
        end else begin
          ovr_d = ovr_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (DI_valid) begin
          ovr_d = 1'b1;
        end else begin
          ovr_d = ovr_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      neg_q     <= '0;
      ovr_q     <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_dat_q  <= '0;
      do_vld_q  <= 1'b0;
      do_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      neg_q     <= neg_d;
      ovr_q     <= ovr_d;
      s1_vld_q  <= s1_vld_d;
      s1_dat_q  <= s1_dat_d;
      do_vld_q  <= do_vld_d;
      do_q      <= do_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign DO_valid = do_vld_q;
  assign DO       = do_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign neg_cnt  = neg_q;
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_relu_engine.sv
// Self-checking bench for relu_engine: per-cycle stimulus tables compared against
// a job-level timeline model (accept times, +2 output latency, done/busy windows).
module tb_relu_engine;

  localparam int MAXC = 1100;

  logic        clk;
  logic        rst;
  logic        start;
  logic [9:0]  n;
  logic        DI_valid;
  logic [15:0] DI;
  logic        DO_valid;
  logic [15:0] DO;
  logic        busy;
  logic        done;
  logic [9:0]  neg_cnt;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  // stimulus tables, one entry per clock edge
  logic        st_a [MAXC];
  logic        dv_a [MAXC];
  logic        rs_a [MAXC];
  logic [9:0]  n_a  [MAXC];
  logic [15:0] d_a  [MAXC];

  // expected values observed just after each edge
  logic        exp_dv   [MAXC];
  logic [15:0] exp_do   [MAXC];
  logic        exp_done [MAXC];
  logic        exp_busy [MAXC];
  logic [9:0]  exp_neg  [MAXC];
  logic        exp_ovr  [MAXC];

  relu_engine #(.DATA_W(16), .CNT_W(10)) dut (
    .clk(clk), .rst(rst), .start(start), .n(n),
    .DI_valid(DI_valid), .DI(DI),
    .DO_valid(DO_valid), .DO(DO), .busy(busy), .done(done),
    .neg_cnt(neg_cnt), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [29:0] obs();
    return {DO_valid, DO, done, busy, neg_cnt, overrun};
  endfunction

  function automatic logic [29:0] expv(input int e);
    return {exp_dv[e], exp_do[e], exp_done[e], exp_busy[e], exp_neg[e], exp_ovr[e]};
  endfunction

  task automatic clear_stim();
    for (int i = 0; i < MAXC; i++) begin
      st_a[i] = 1'b0; dv_a[i] = 1'b0; rs_a[i] = 1'b0; n_a[i] = 10'd0; d_a[i] = 16'd0;
    end
  endtask

  task automatic beat(input int e, input logic [15:0] d);
    dv_a[e] = 1'b1;
    d_a[e]  = d;
  endtask

  // Job timeline model: start at s, beats accepted after s until n taken (last at L),
  // each output 1 edge after acceptance, done at D=L+2 (D=s for n=0), idle after D+1.
  task automatic build_model(input int len);
    int job, s, nl, acc, L, D, idle_from;
    logic [9:0] neg;
    logic ovr;
    job = 0; s = 0; nl = 0; acc = 0; L = -1; D = -1; idle_from = 0; neg = 10'd0; ovr = 1'b0;
    for (int i = 0; i < MAXC; i++) begin
      exp_dv[i] = 1'b0; exp_do[i] = 16'd0; exp_done[i] = 1'b0;
      exp_busy[i] = 1'b0; exp_neg[i] = 10'd0; exp_ovr[i] = 1'b0;
    end
    for (int e = 0; e < len; e++) begin
      if (rs_a[e]) begin
        job = 0; neg = 10'd0; ovr = 1'b0; idle_from = e + 1;
        for (int k = e; k < MAXC; k++) begin
          exp_dv[k] = 1'b0; exp_do[k] = 16'd0;
        end
      end else if (job == 0 && st_a[e] && e >= idle_from) begin
        job = 1; s = e; nl = int'(n_a[e]); acc = 0; neg = 10'd0; ovr = 1'b0;
        if (nl == 0) begin L = e; D = e; end
        else begin L = -1; D = -1; end
      end else if (job == 1) begin
        if (L < 0) begin
          if (dv_a[e]) begin
            exp_dv[e+1] = 1'b1;
            exp_do[e+1] = d_a[e][15] ? 16'd0 : d_a[e];
            if (d_a[e][15]) neg = neg + 10'd1;
            acc++;
            if (acc == nl) begin L = e; D = e + 2; end
          end
        end else if (dv_a[e]) begin
          ovr = 1'b1;
        end
      end
      exp_busy[e] = (job == 1) && (L < 0 || e <= D);
      exp_done[e] = (job == 1) && (L >= 0) && (e == D);
      exp_neg[e]  = neg;
      exp_ovr[e]  = ovr;
      if (job == 1 && L >= 0 && e == D + 1) begin
        job = 0; idle_from = e + 1;
      end
    end
  endtask

  task automatic step(input int e);
    rst = rs_a[e]; start = st_a[e]; n = n_a[e]; DI_valid = dv_a[e]; DI = d_a[e];
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_stim();
    rs_a[0] = 1'b1; rs_a[1] = 1'b1; st_a[1] = 1'b1; n_a[1] = 10'd3; beat(1, 16'h1234);
    st_a[2] = 1'b1; n_a[2] = 10'd1; beat(3, 16'h0042);
    build_model(10);
    for (int e = 0; e < 10; e++) begin
      step(e);
      if (e == 1) begin
        checks++;
        if ({DO_valid, DO, busy, done, neg_cnt, overrun} !== 30'd0) begin
          errors++; $display("FAIL reset_state got %h required 0", {DO_valid, DO, busy, done, neg_cnt, overrun});
        end
      end
      checks++;
      if (obs() !== expv(e)) begin
        errors++; $display("FAIL reset e=%0d got %h required %h", e, obs(), expv(e));
      end
    end
  endtask

  task automatic test_basic();
    int ndone;
    ndone = 0;
    clear_stim();
    rs_a[0] = 1'b1; st_a[1] = 1'b1; n_a[1] = 10'd4;
    beat(2, 16'd5); beat(3, 16'hFFFD); beat(4, 16'd0); beat(5, 16'h8000);
    build_model(12);
    for (int e = 0; e < 12; e++) begin
      step(e);
      if (done) ndone++;
      checks++;
      if (obs() !== expv(e)) begin
        errors++; $display("FAIL basic e=%0d got %h required %h", e, obs(), expv(e));
      end
    end
    checks++;
    if (neg_cnt !== 10'd2 || ndone != 1) begin
      errors++; $display("FAIL basic_summary neg_cnt=%0d dones=%0d required 2 and 1", neg_cnt, ndone);
    end
  endtask

  task automatic test_gapped();
    clear_stim();
    rs_a[0] = 1'b1; st_a[1] = 1'b1; n_a[1] = 10'd3;
    beat(2, 16'd7); beat(5, 16'hFFFF); beat(8, 16'd9);
    build_model(16);
    for (int e = 0; e < 16; e++) begin
      step(e);
      checks++;
      if (obs() !== expv(e)) begin
        errors++; $display("FAIL gapped e=%0d got %h required %h", e, obs(), expv(e));
      end
    end
  endtask

  task automatic test_zero_len();
    int nbusy;
    nbusy = 0;
    clear_stim();
    rs_a[0] = 1'b1; st_a[1] = 1'b1; n_a[1] = 10'd0;
    build_model(6);
    for (int e = 0; e < 6; e++) begin
      step(e);
      if (busy) nbusy++;
      checks++;
      if (obs() !== expv(e)) begin
        errors++; $display("FAIL zero_len e=%0d got %h required %h", e, obs(), expv(e));
      end
    end
    checks++;
    if (nbusy != 1) begin
      errors++; $display("FAIL zero_len_busy got %0d cycles required 1", nbusy);
    end
  endtask

  task automatic test_overrun();
    clear_stim();
    rs_a[0] = 1'b1; st_a[1] = 1'b1; n_a[1] = 10'd2;
    beat(2, 16'd1); beat(3, 16'd2); beat(4, 16'd3);
    st_a[12] = 1'b1; n_a[12] = 10'd1; beat(13, 16'd4);
    build_model(18);
    for (int e = 0; e < 18; e++) begin
      step(e);
      if (e == 10) begin
        checks++;
        if (overrun !== 1'b1 || busy !== 1'b0) begin
          errors++; $display("FAIL overrun_held overrun=%b busy=%b required 1 0", overrun, busy);
        end
      end
      if (e == 12) begin
        checks++;
        if (overrun !== 1'b0) begin
          errors++; $display("FAIL overrun_clear got %b required 0", overrun);
        end
      end
      checks++;
      if (obs() !== expv(e)) begin
        errors++; $display("FAIL overrun e=%0d got %h required %h", e, obs(), expv(e));
      end
    end
  endtask

  task automatic test_start_collision();
    int nout;
    logic [15:0] last;
    nout = 0; last = 16'd0;
    clear_stim();
    rs_a[0] = 1'b1; st_a[1] = 1'b1; n_a[1] = 10'd1; beat(1, 16'd11);
    beat(2, 16'd12); st_a[2] = 1'b1; n_a[2] = 10'd5;
    build_model(10);
    for (int e = 0; e < 10; e++) begin
      step(e);
      if (DO_valid) begin nout++; last = DO; end
      checks++;
      if (obs() !== expv(e)) begin
        errors++; $display("FAIL collision e=%0d got %h required %h", e, obs(), expv(e));
      end
    end
    checks++;
    if (nout != 1 || last !== 16'd12) begin
      errors++; $display("FAIL collision_out got %0d outputs last=%0d required 1 output of 12", nout, last);
    end
  endtask

  task automatic test_reset_mid_job();
    clear_stim();
    rs_a[0] = 1'b1; st_a[1] = 1'b1; n_a[1] = 10'd8;
    beat(2, 16'd3); beat(3, 16'hFF00); beat(4, 16'd6);
    rs_a[5] = 1'b1; beat(5, 16'd8); beat(6, 16'd9); beat(7, 16'd10);
    st_a[9] = 1'b1; n_a[9] = 10'd1; beat(10, 16'h7FFF);
    build_model(18);
    for (int e = 0; e < 18; e++) begin
      step(e);
      if (e == 5) begin
        checks++;
        if ({DO_valid, DO, busy, done, neg_cnt, overrun} !== 30'd0) begin
          errors++; $display("FAIL midreset_state got %h required 0", {DO_valid, DO, busy, done, neg_cnt, overrun});
        end
      end
      checks++;
      if (obs() !== expv(e)) begin
        errors++; $display("FAIL midreset e=%0d got %h required %h", e, obs(), expv(e));
      end
    end
  endtask

  task automatic test_max_len();
    int ndone;
    ndone = 0;
    clear_stim();
    rs_a[0] = 1'b1; st_a[1] = 1'b1; n_a[1] = 10'd1023;
    for (int i = 0; i < 1023; i++) beat(2 + i, 16'($urandom));
    build_model(1032);
    for (int e = 0; e < 1032; e++) begin
      step(e);
      if (done) ndone++;
      checks++;
      if (obs() !== expv(e)) begin
        errors++; $display("FAIL max_len e=%0d got %h required %h", e, obs(), expv(e));
      end
    end
    checks++;
    if (ndone != 1) begin
      errors++; $display("FAIL max_len_done got %0d pulses required 1", ndone);
    end
  endtask

  task automatic test_random();
    clear_stim();
    rs_a[0] = 1'b1;
    for (int e = 1; e < 800; e++) begin
      rs_a[e] = ($urandom_range(0, 149) == 0);
      st_a[e] = ($urandom_range(0, 5) == 0);
      n_a[e]  = 10'($urandom_range(0, 12));
      dv_a[e] = ($urandom_range(0, 9) < 6);
      d_a[e]  = 16'($urandom);
    end
    build_model(800);
    for (int e = 0; e < 800; e++) begin
      step(e);
      checks++;
      if (obs() !== expv(e)) begin
        errors++; $display("FAIL random e=%0d got %h required %h", e, obs(), expv(e));
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; n = 10'd0; DI_valid = 1'b0; DI = 16'd0;
    test_reset();
    test_basic();
    test_gapped();
    test_zero_len();
    test_overrun();
    test_start_collision();
    test_reset_mid_job();
    test_max_len();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/relu_engine.md
RELU_ENGINE -- requirements
Module: relu_engine

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning data word width (two's-complement signed).
REQ-002 The block SHALL have parameter CNT_W, default 10, meaning width of the length and beat counters.
REQ-003 The block SHALL have a port clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have a port rst, input, width 1: reset, synchronous and active-high.
REQ-005 The block SHALL have a port start, input, width 1: one-cycle request to begin a job.
REQ-006 The block SHALL have a port n, input, width CNT_W: job length in beats, sampled only when start is accepted.
REQ-007 The block SHALL have a port DI_valid, input, width 1: input beat qualifier.
REQ-008 The block SHALL have a port DI, input, width DATA_W: input word.
REQ-009 The block SHALL have a port DO_valid, output, width 1: output beat qualifier.
REQ-010 The block SHALL have a port DO, output, width DATA_W: output word, max(DI, 0).
REQ-011 The block SHALL have a port busy, output, width 1: high while state is not IDLE.
REQ-012 The block SHALL have a port done, output, width 1: one-cycle job-complete pulse.
REQ-013 The block SHALL have a port neg_cnt, output, width CNT_W: number of accepted beats of the current or last job with DI < 0.
REQ-014 The block SHALL have a port overrun, output, width 1: sticky flag for a DI_valid beat outside RUN while busy.

Function
REQ-015 The FSM SHALL have the states IDLE, RUN, DRAIN and DONE.
REQ-016 In IDLE, start=1 SHALL latch n, clear in_cnt, out_cnt, neg_cnt and overrun, and move to RUN if n!=0, otherwise to DONE.
REQ-017 The block SHALL accept a beat in RUN only; a beat is accepted when DI_valid=1, and each accepted beat increments in_cnt.
REQ-018 On the accepted beat that makes in_cnt equal to the latched n, the FSM SHALL move to DRAIN.
REQ-019 The pipeline SHALL have 2 stages: an accepted beat at cycle t appears with DO_valid=1 at cycle t+2, one output per input, order preserved, with no bubbles inserted.
REQ-020 The output SHALL be DO = 0 if DI[DATA_W-1]=1, else DO = DI; zero passes unchanged; the most-negative value maps to 0.
REQ-021 neg_cnt SHALL increment by 1 per accepted beat with sign bit set; it cannot exceed n, so no saturation is needed.
REQ-022 out_cnt SHALL count DO_valid beats; in DRAIN, when out_cnt reaches n (last output emitted), the FSM SHALL move to DONE the next cycle.
REQ-023 In DONE, done SHALL be 1 for exactly one cycle, after which the FSM returns to IDLE.
REQ-024 neg_cnt and overrun SHALL hold their values after done until the next accepted start.
REQ-025 start SHALL be ignored in RUN, DRAIN and DONE; n changes outside start acceptance SHALL have no effect.
REQ-026 A DI_valid beat in the same cycle that start is accepted SHALL be ignored; the first acceptable beat is in the cycle after.
REQ-027 A DI_valid beat in DRAIN or DONE SHALL be dropped (no DO, no count change) and SHALL set overrun=1.
REQ-028 A DI_valid beat in IDLE SHALL be dropped silently, without setting overrun.
REQ-029 DO SHALL be 0 whenever DO_valid=0.
REQ-030 The latched n SHALL be used at full CNT_W width; n=2^CNT_W-1 (1023) SHALL be supported with no counter wrap.

Reset
REQ-031 When rst=1 at a clock edge, the block SHALL enter IDLE and force DO_valid=0, DO=0, busy=0, done=0, neg_cnt=0 and overrun=0, and clear in_cnt, out_cnt and both pipeline stages.
REQ-032 A reset asserted mid-job SHALL discard in-flight beats: no DO_valid and no done are produced for that job after rst deasserts.
REQ-033 The first start SHALL be accepted in the first cycle with rst=0.

Verification
REQ-034 Basic: start with n=4, then DI = 5, -3, 0, 0x8000 on 4 consecutive cycles -> DO = 5, 0, 0, 0 on cycles t+2..t+5, neg_cnt=2, single done pulse, busy falls with done.
REQ-035 Gapped input: n=3, beats 7, -1, 9 with 2 idle cycles between each -> DO_valid exactly 3 times, each 2 cycles after its input, done after the third output.
REQ-036 Zero length: start with n=0 -> busy=1 for 1 cycle, done pulse, no DO_valid, neg_cnt=0.
REQ-037 Overrun: n=2, send 3 consecutive beats -> 2 outputs, overrun=1 and held through IDLE, cleared by next start.
REQ-038 Start collision: start with DI_valid=1 (DI=11) in the same cycle, n=1, then DI=12 -> only DO=12 is output; a second start during RUN is ignored.
REQ-039 Reset mid-job: n=8, rst=1 after 3 beats -> all outputs 0 next cycle, no later DO_valid/done; a new job with n=1 completes normally.
